// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, one-outstanding imem req/ack handshake, 1-entry skid
// for decode stall, and flush/redirect with a DROP state for an abandoned in-flight request.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
);

  localparam logic [1:0] ST_RST   = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DROP  = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pending_pc;
  logic [31:0] skid_pc;
  logic [31:0] skid_inst;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [31:0] redirect_aligned;
  logic [31:0] reset_aligned;

  assign redirect_aligned = redirect_pc_i & ~32'h3;
  assign reset_aligned    = RESET_PC & ~32'h3;

  // pc is not advanced on a flush that hits an outstanding request, so it keeps
  // driving the pre-flush address while DROP waits for the stale ack.
  assign imem_req_o  = (state == ST_FETCH) || (state == ST_DROP);
  assign imem_addr_o = pc;
  assign id_valid_o  = out_valid;
  assign id_pc_o     = out_pc;
  assign id_inst_o   = out_inst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_RST;
      pc         <= reset_aligned;
      pending_pc <= '0;
      skid_pc    <= '0;
      skid_inst  <= '0;
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_inst   <= '0;
    end else if (flush_i) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_inst  <= '0;
      skid_pc   <= '0;
      skid_inst <= '0;
      case (state)
        ST_FETCH: begin
          if (imem_ack_i) begin
            pc    <= redirect_aligned;
            state <= ST_FETCH;
          end else begin
            pending_pc <= redirect_aligned;
            state      <= ST_DROP;
          end
        end
        ST_DROP: pending_pc <= redirect_aligned;
        default: begin
          pc    <= redirect_aligned;
          state <= ST_FETCH;
        end
      endcase
    end else begin
      case (state)
        ST_RST: state <= ST_FETCH;
        ST_FETCH: begin
          if (imem_ack_i) begin
            pc <= pc + 32'd4;
            if (!out_valid || !stall_i) begin
              out_valid <= 1'b1;
              out_pc    <= pc;
              out_inst  <= imem_rdata_i;
            end else begin
              skid_pc   <= pc;
              skid_inst <= imem_rdata_i;
              state     <= ST_HOLD;
            end
          end else if (!stall_i) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= '0;
          end
        end
        ST_HOLD: begin
          if (!stall_i) begin
            out_valid <= 1'b1;
            out_pc    <= skid_pc;
            out_inst  <= skid_inst;
            skid_pc   <= '0;
            skid_inst <= '0;
            state     <= ST_FETCH;
          end
        end
        default: begin
          if (imem_ack_i) begin
            pc    <= pending_pc;
            state <= ST_FETCH;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: each step drives one cycle of inputs, checks the
// handshake outputs, and checks decode-side output against a queue of expected fetches.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [63:0] sb[$];

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .redirect_pc_i(redirect_pc_i),
    .id_valid_o   (id_valid_o),
    .id_pc_o      (id_pc_o),
    .id_inst_o    (id_inst_o)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: observed no finish, expected finish before 50000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs at posedge+1, check outputs, then advance to next posedge+1.
  task automatic step(input logic a, input logic s, input logic f, input logic [31:0] rpc,
                      input logic ereq, input logic [31:0] eaddr, input logic keep,
                      input logic ev);
    logic [63:0] front;
    imem_ack_i    = a;
    stall_i       = s;
    flush_i       = f;
    redirect_pc_i = rpc;
    imem_rdata_i  = a ? (eaddr | 32'hA500_0000) : 32'hDEAD_BEEF;
    chk("imem_req", {31'b0, imem_req_o}, {31'b0, ereq});
    if (ereq) chk("imem_addr", imem_addr_o, eaddr);
    chk("id_valid", {31'b0, id_valid_o}, {31'b0, ev});
    if (!id_valid_o) begin
      chk("bubble_pc", id_pc_o, 32'h0);
      chk("bubble_inst", id_inst_o, 32'h0);
    end else if (sb.size() == 0) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL sb_empty: observed valid pc %h expected no instruction", id_pc_o);
      end
    end else begin
      front = sb[0];
      chk("id_pc", id_pc_o, front[63:32]);
      chk("id_inst", id_inst_o, front[31:0]);
      if (!s && !f) void'(sb.pop_front());
    end
    if (f) sb.delete();
    if (a && keep) sb.push_back({eaddr, eaddr | 32'hA500_0000});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    imem_ack_i = 1'b0;
    imem_rdata_i = '0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    redirect_pc_i = '0;
    #12;
    chk("rst_req", {31'b0, imem_req_o}, 32'h0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_valid", {31'b0, id_valid_o}, 32'h0);
    chk("rst_pc", id_pc_o, 32'h0);
    chk("rst_inst", id_inst_o, 32'h0);
    #1 rst = 1'b1;

    //    ack  stl  fl   redirect      req  addr          keep valid
    step(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0); // RST
    step(1'b1,1'b0,1'b0,32'h0,        1'b1,32'h0,        1'b1,1'b0);
    step(1'b1,1'b0,1'b0,32'h0,        1'b1,32'h4,        1'b1,1'b1);
    step(1'b1,1'b0,1'b0,32'h0,        1'b1,32'h8,        1'b1,1'b1);
    // stall with output at 8 while 0xC is acked -> skid, HOLD
    step(1'b1,1'b1,1'b0,32'h0,        1'b1,32'hC,        1'b1,1'b1);
    step(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h10,       1'b0,1'b1);
    step(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h10,       1'b0,1'b1);
    step(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h10,       1'b0,1'b1);
    // 0x10 ack delayed, flush to 0x100 while outstanding
    step(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h10,       1'b0,1'b1);
    step(1'b0,1'b0,1'b1,32'h100,      1'b1,32'h10,       1'b0,1'b0);
    step(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h10,       1'b0,1'b0);
    step(1'b1,1'b0,1'b0,32'h0,        1'b1,32'h10,       1'b0,1'b0);
    // flush with misaligned redirect in the ack cycle
    step(1'b1,1'b0,1'b1,32'h103,      1'b1,32'h100,      1'b0,1'b0);
    step(1'b1,1'b0,1'b0,32'h0,        1'b1,32'h100,      1'b1,1'b0);
    step(1'b1,1'b0,1'b0,32'h0,        1'b1,32'h104,      1'b1,1'b1);
    // redirect to the top of the address space, pc wraps
    step(1'b1,1'b0,1'b1,32'hFFFF_FFFC,1'b1,32'h108,      1'b0,1'b1);
    step(1'b1,1'b0,1'b0,32'h0,        1'b1,32'hFFFF_FFFC,1'b1,1'b0);
    step(1'b1,1'b0,1'b0,32'h0,        1'b1,32'h0,        1'b1,1'b1);
    step(1'b1,1'b0,1'b0,32'h0,        1'b1,32'h4,        1'b1,1'b1);

    // asynchronous reset mid-FETCH with a valid instruction presented
    chk("pre_rst_valid", {31'b0, id_valid_o}, 32'h1);
    imem_ack_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_req", {31'b0, imem_req_o}, 32'h0);
    chk("async_valid", {31'b0, id_valid_o}, 32'h0);
    chk("async_pc", id_pc_o, 32'h0);
    chk("async_inst", id_inst_o, 32'h0);
    chk("async_addr", imem_addr_o, 32'h0);
    sb.delete();
    #2 rst = 1'b1;
    step(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0);
    step(1'b1,1'b0,1'b0,32'h0,        1'b1,32'h0,        1'b1,1'b0);
    step(1'b1,1'b0,1'b0,32'h0,        1'b1,32'h4,        1'b1,1'b1);
    step(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h8,        1'b0,1'b1);
    step(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h8,        1'b0,1'b0);
    chk("sb_drained", sb.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
